// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and counter width for the ALU driver slice.
package alu_pkg;

  localparam logic [2:0] OP_AND     = 3'b000;
  localparam logic [2:0] OP_OR      = 3'b001;
  localparam logic [2:0] OP_ADD     = 3'b010;
  localparam logic [2:0] OP_SUB     = 3'b011;
  localparam logic [2:0] OP_LT      = 3'b100;
  localparam logic [2:0] OP_GE      = 3'b101;
  localparam logic [2:0] OP_EQ      = 3'b110;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  // Holds ALU_LAT+1 for ALU_LAT up to 7.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_driver_ref_model.sv
// Combinational expected-result model of the ALU, used by the driver when ALU_DRV_SELFCHECK_EN is defined.
// Latency: none (pure combinational). Backpressure: not applicable.
module alu_ref_model
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] exp_data,
  output logic             exp_zero
);

  always_comb begin
    exp_data = '0;
    case (op)
      OP_AND:  exp_data = a & b;
      OP_OR:   exp_data = a | b;
      OP_ADD:  exp_data = a + b;
      OP_SUB:  exp_data = a - b;
      OP_LT:   exp_data = {{(WIDTH-1){1'b0}}, ($signed(a) <  $signed(b))};
      OP_GE:   exp_data = {{(WIDTH-1){1'b0}}, ($signed(a) >= $signed(b))};
      OP_EQ:   exp_data = {{(WIDTH-1){1'b0}}, (a == b)};
      default: exp_data = '0;
    endcase
    exp_zero = (exp_data == '0);
  end

endmodule

// File: rtl/alu_driver.sv
// Initiator-side sequencer for the clocked ALU; optional result self-check under ALU_DRV_SELFCHECK_EN.
// Latency: accept at edge N -> resp_valid from edge N+ALU_LAT+1 (illegal opcode: from edge N).
// Backpressure: one op in flight; req_ready low from accept until the response handshake.
module alu_driver
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_zero,
  output logic             resp_err
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   alu_a_q, alu_a_d;
  logic [WIDTH-1:0]   alu_b_q, alu_b_d;
  logic [2:0]         alu_ctrl_q, alu_ctrl_d;
  logic [WIDTH-1:0]   resp_data_q, resp_data_d;
  logic               resp_zero_q, resp_zero_d;
  logic               resp_err_q, resp_err_d;
  logic               accept;
  logic               capture;
  logic               mism;

  assign accept  = (state_q == IDLE) && req_valid;
  assign capture = (state_q == WAIT) && (cnt_q == CNT_W'(1));

`ifdef ALU_DRV_SELFCHECK_EN
  logic [WIDTH-1:0] ref_data;
  logic             ref_zero;
  logic [WIDTH-1:0] exp_data_q, exp_data_d;
  logic             exp_zero_q, exp_zero_d;
  logic [15:0]      mism_cnt_q, mism_cnt_d;

  alu_ref_model #(.WIDTH(WIDTH)) u_ref (
    .op       (req_op),
    .a        (req_a),
    .b        (req_b),
    .exp_data (ref_data),
    .exp_zero (ref_zero)
  );

  assign mism = (alu_out != exp_data_q) || (alu_zero != exp_zero_q);

  always_comb begin
    exp_data_d = exp_data_q;
    exp_zero_d = exp_zero_q;
    mism_cnt_d = mism_cnt_q;
    if (accept && (req_op != OP_ILLEGAL)) begin
      exp_data_d = ref_data;
      exp_zero_d = ref_zero;
    end
    if (capture && mism && (mism_cnt_q != 16'hFFFF)) begin
      mism_cnt_d = mism_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_data_q <= '0;
      exp_zero_q <= 1'b0;
      mism_cnt_q <= '0;
    end else begin
      exp_data_q <= exp_data_d;
      exp_zero_q <= exp_zero_d;
      mism_cnt_q <= mism_cnt_d;
    end
  end
`else
  assign mism = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_ctrl_d  = alu_ctrl_q;
    resp_data_d = resp_data_q;
    resp_zero_d = resp_zero_q;
    resp_err_d  = resp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_op == OP_ILLEGAL) begin
            state_d     = RESP;
            resp_data_d = '0;
            resp_zero_d = 1'b0;
            resp_err_d  = 1'b1;
          end else begin
            // One extra cycle covers the edge that registers the operands into the ALU.
            state_d    = WAIT;
            cnt_d      = CNT_W'(ALU_LAT + 1);
            alu_a_d    = req_a;
            alu_b_d    = req_b;
            alu_ctrl_d = req_op;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (capture) begin
          state_d     = RESP;
          resp_data_d = alu_out;
          resp_zero_d = alu_zero;
          resp_err_d  = mism;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d    = IDLE;
          resp_err_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_ctrl_q  <= OP_AND;
      resp_data_q <= '0;
      resp_zero_q <= 1'b0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_ctrl_q  <= alu_ctrl_d;
      resp_data_q <= resp_data_d;
      resp_zero_q <= resp_zero_d;
      resp_err_q  <= resp_err_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign resp_valid  = (state_q == RESP);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_control = alu_ctrl_q;
  assign resp_data   = resp_data_q;
  assign resp_zero   = resp_zero_q;
  assign resp_err    = resp_err_q;

endmodule

// File: tb/tb_alu_driver.sv
// Directed bench for alu_driver with a behavioural one-cycle ALU attached to its alu_* pins.
module tb_alu_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_control;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_zero;
  logic        resp_err;

  int total = 0;
  int bad   = 0;

  logic [31:0] alu_out_r;
  logic        force_six = 1'b0;

  always #5 clk = ~clk;

  alu_driver #(.WIDTH(32), .ALU_LAT(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_control (alu_control),
    .alu_out     (alu_out),
    .alu_zero    (alu_zero),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .resp_zero   (resp_zero),
    .resp_err    (resp_err)
  );

  // Clocked ALU: registered result one cycle after its inputs change.
  always @(posedge clk) begin
    case (alu_control)
      3'b000:  alu_out_r <= alu_a & alu_b;
      3'b001:  alu_out_r <= alu_a | alu_b;
      3'b010:  alu_out_r <= alu_a + alu_b;
      3'b011:  alu_out_r <= alu_a - alu_b;
      3'b100:  alu_out_r <= {31'd0, ($signed(alu_a) <  $signed(alu_b))};
      3'b101:  alu_out_r <= {31'd0, ($signed(alu_a) >= $signed(alu_b))};
      3'b110:  alu_out_r <= {31'd0, (alu_a == alu_b)};
      default: alu_out_r <= 32'd0;
    endcase
  end

  assign alu_out  = force_six ? 32'd6 : alu_out_r;
  assign alu_zero = (alu_out_r == 32'd0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the driver idle; returns at a negedge.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_data,
                        input logic exp_zero, input logic exp_err);
    int n;
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = 3'b000;
    req_a     = 32'hDEAD_BEEF;
    req_b     = 32'h1234_5678;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_data"}, resp_data, exp_data);
    check({tag, "_zero"}, {31'd0, resp_zero}, {31'd0, exp_zero});
    check({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
    if (resp_ready) begin
      @(negedge clk);
      check({tag, "_done_valid"}, {31'd0, resp_valid}, 32'd0);
      check({tag, "_done_ready"}, {31'd0, req_ready}, 32'd1);
      check({tag, "_done_err"}, {31'd0, resp_err}, 32'd0);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_op     = 3'b000;
    req_a      = 32'd0;
    req_b      = 32'd0;
    resp_ready = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_resp_zero", {31'd0, resp_zero}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_alu_control", {29'd0, alu_control}, 32'd0);

    rst_n      = 1'b1;
    resp_ready = 1'b1;
    @(negedge clk);

    run_op("add_3_2", 3'b010, 32'd3, 32'd2, 2, 32'd5, 1'b0, 1'b0);
    check("add_alu_a_held", alu_a, 32'd3);
    check("add_alu_b_held", alu_b, 32'd2);
    run_op("sub_7_7", 3'b011, 32'd7, 32'd7, 2, 32'd0, 1'b1, 1'b0);
    run_op("and_3_2", 3'b000, 32'd3, 32'd2, 2, 32'd2, 1'b0, 1'b0);

    req_a = 32'd9;
    run_op("illegal", 3'b111, 32'd9, 32'd8, 0, 32'd0, 1'b0, 1'b1);
    check("illegal_ctrl_kept", {29'd0, alu_control}, 32'd0);
    check("illegal_a_kept", alu_a, 32'd3);

    // Consumer stalls for five cycles; a new request arriving meanwhile must be ignored.
    resp_ready = 1'b0;
    run_op("or_hold", 3'b001, 32'd3, 32'd2, 2, 32'd3, 1'b0, 1'b0);
    req_valid = 1'b1;
    req_op    = 3'b010;
    req_a     = 32'd100;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, resp_valid}, 32'd1);
      check("hold_data", resp_data, 32'd3);
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
      check("hold_alu_control", {29'd0, alu_control}, 32'd1);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    check("hold_release_valid", {31'd0, resp_valid}, 32'd0);
    check("hold_release_ready", {31'd0, req_ready}, 32'd1);

    // Reset lands while an LT op is waiting on the ALU.
    req_valid = 1'b1;
    req_op    = 3'b100;
    req_a     = 32'd3;
    req_b     = 32'd2;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("midop_in_wait", {31'd0, req_ready}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("arst_req_ready", {31'd0, req_ready}, 32'd1);
    check("arst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("arst_alu_a", alu_a, 32'd0);
    check("arst_alu_b", alu_b, 32'd0);
    check("arst_alu_control", {29'd0, alu_control}, 32'd0);
    check("arst_resp_data", resp_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_no_resp", {31'd0, resp_valid}, 32'd0);
    end

    run_op("lt_3_2", 3'b100, 32'd3, 32'd2, 2, 32'd0, 1'b1, 1'b0);
    run_op("ge_3_2", 3'b101, 32'd3, 32'd2, 2, 32'd1, 1'b0, 1'b0);
    run_op("eq_3_2", 3'b110, 32'd3, 32'd2, 2, 32'd0, 1'b1, 1'b0);
    run_op("lt_neg1_2", 3'b100, 32'hFFFF_FFFF, 32'd2, 2, 32'd1, 1'b0, 1'b0);
    run_op("add_wrap", 3'b010, 32'hFFFF_FFFF, 32'd1, 2, 32'd0, 1'b1, 1'b0);

`ifdef ALU_DRV_SELFCHECK_EN
    force_six = 1'b1;
    run_op("selfcheck_bad_add", 3'b010, 32'd3, 32'd2, 2, 32'd6, 1'b0, 1'b1);
    force_six = 1'b0;
    run_op("selfcheck_good_add", 3'b010, 32'd3, 32'd2, 2, 32'd5, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
